regfile_mp: RTL and testbench

//  Multi-port integer register file for the pipelined CPU; successor to the single-write/2-read file.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 66 ++++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the pipelined CPU integer register file.
//   DEF_DATA_W  : default register width
//   DEF_NUM_REG : default register count (power of two)
//   DEF_ADDR_W  : default register address width, derived from DEF_NUM_REG
//   REG_ZERO    : index of the hard-wired zero register
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_NUM_REG = 32;
  localparam int DEF_ADDR_W  = $clog2(DEF_NUM_REG);
  localparam int REG_ZERO    = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// ----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port of the multi-port register file: array mux,
// optional write->read bypass and busy-bit lookup.
// Ports:
//   i_rst                 : synchronous reset of the parent; forces zero outputs
//   i_Addr                : read address
//   i_Regs / i_Busy       : current register array contents and busy vector
//   i_WrEn*/i_WrReg*/i_WrData* : the two write ports of this cycle (bypass source)
//   o_Data / o_Busy       : read data and busy bit for i_Addr
// ----------------------------------------------------------------------------
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REG  = DEF_NUM_REG,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [DATA_W-1:0] i_Regs [NUM_REG],
  input  logic [NUM_REG-1:0] i_Busy,
  input  logic              i_WrEn0,
  input  logic [ADDR_W-1:0] i_WrReg0,
  input  logic [DATA_W-1:0] i_WrData0,
  input  logic              i_WrEn1,
  input  logic [ADDR_W-1:0] i_WrReg1,
  input  logic [DATA_W-1:0] i_WrData1,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Busy
);

  logic hit0;
  logic hit1;
  logic isZero;

  assign hit0   = i_WrEn0 && (i_WrReg0 == i_Addr);
  assign hit1   = i_WrEn1 && (i_WrReg1 == i_Addr);
  assign isZero = (ZERO_REG != 0) && (i_Addr == ADDR_W'(REG_ZERO));

  // Start from the stored value, let this cycle's writes override it when
  // bypass is enabled (load port has priority, matching the write priority),
  // then force zero for the hard-wired register and during reset.
  always_comb begin
    o_Data = i_Regs[i_Addr];
    o_Busy = i_Busy[i_Addr];
    if (BYPASS != 0) begin
      if (hit1) begin
        o_Data = i_WrData1;
      end else if (hit0) begin
        o_Data = i_WrData0;
      end
      // A producer writing back this cycle means the value is ready now.
      if (hit0 || hit1) begin
        o_Busy = 1'b0;
      end
    end
    if (i_rst || isZero) begin
      o_Data = '0;
      o_Busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
// Multi-port integer register file with per-register busy scoreboard.
// Ports:
//   i_clk, i_rst          : clock and synchronous active-high reset
//   i_ReadReg/o_ReadData/o_ReadBusy : NUM_RD packed combinational read ports
//   i_WrEn0/i_WrReg0/i_WrData0      : ALU writeback port
//   i_WrEn1/i_WrReg1/i_WrData1      : load writeback port (wins on conflict)
//   i_Alloc/i_AllocReg    : mark a register busy for a long-latency producer
//   i_ProbeReg/o_ProbeData: debug view of stored contents (no bypass)
// ----------------------------------------------------------------------------
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REG  = DEF_NUM_REG,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REG)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_ReadReg,
  output logic [NUM_RD*DATA_W-1:0] o_ReadData,
  output logic [NUM_RD-1:0]        o_ReadBusy,
  input  logic                     i_WrEn0,
  input  logic [ADDR_W-1:0]        i_WrReg0,
  input  logic [DATA_W-1:0]        i_WrData0,
  input  logic                     i_WrEn1,
  input  logic [ADDR_W-1:0]        i_WrReg1,
  input  logic [DATA_W-1:0]        i_WrData1,
  input  logic                     i_Alloc,
  input  logic [ADDR_W-1:0]        i_AllocReg,
  input  logic [ADDR_W-1:0]        i_ProbeReg,
  output logic [DATA_W-1:0]        o_ProbeData
);

  logic [DATA_W-1:0]  regs_q [NUM_REG];
  logic [DATA_W-1:0]  regs_d [NUM_REG];
  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;

  logic wrOk0;
  logic wrOk1;
  logic allocOk;

  // Requests aimed at the hard-wired zero register are dropped here so the
  // array entry for it stays zero forever.
  assign wrOk0   = i_WrEn0 && !((ZERO_REG != 0) && (i_WrReg0 == ADDR_W'(REG_ZERO)));
  assign wrOk1   = i_WrEn1 && !((ZERO_REG != 0) && (i_WrReg1 == ADDR_W'(REG_ZERO)));
  assign allocOk = i_Alloc && !((ZERO_REG != 0) && (i_AllocReg == ADDR_W'(REG_ZERO)));

  // Next-state: port 1 is applied after port 0 so it wins on a shared
  // address; the alloc is applied last so a new producer keeps the register
  // busy even when an older one writes back in the same cycle.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wrOk0) begin
      regs_d[i_WrReg0] = i_WrData0;
      busy_d[i_WrReg0] = 1'b0;
    end
    if (wrOk1) begin
      regs_d[i_WrReg1] = i_WrData1;
      busy_d[i_WrReg1] = 1'b0;
    end
    if (allocOk) begin
      busy_d[i_AllocReg] = 1'b1;
    end
  end

  // State registers; reset clears data and scoreboard and discards any
  // writes or allocs presented in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign o_ProbeData = i_rst ? '0 : regs_q[i_ProbeReg];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .NUM_REG  (NUM_REG),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .i_rst     (i_rst),
      .i_Addr    (i_ReadReg[k*ADDR_W +: ADDR_W]),
      .i_Regs    (regs_q),
      .i_Busy    (busy_q),
      .i_WrEn0   (i_WrEn0),
      .i_WrReg0  (i_WrReg0),
      .i_WrData0 (i_WrData0),
      .i_WrEn1   (i_WrEn1),
      .i_WrReg1  (i_WrReg1),
      .i_WrData1 (i_WrData1),
      .o_Data    (o_ReadData[k*DATA_W +: DATA_W]),
      .o_Busy    (o_ReadBusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
// Drives two register files from the same stimulus: dut0 with bypass and a
// hard-wired zero register, dut1 with neither. Expected outputs come from a
// behavioural model, are queued when stimulus is applied and popped when the
// outputs are sampled.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [NRD*AW-1:0] readReg;
  logic [NRD*DW-1:0] readData0, readData1;
  logic [NRD-1:0]   readBusy0, readBusy1;
  logic             wrEn0, wrEn1, alloc;
  logic [AW-1:0]    wrReg0, wrReg1, allocReg, probeReg;
  logic [DW-1:0]    wrData0, wrData1;
  logic [DW-1:0]    probeData0, probeData1;

  logic [DW-1:0] modelRegs [2][NR];
  logic          modelBusy [2][NR];
  logic [63:0]   expQ [$];
  int            checkCount = 0;
  int            passCount  = 0;

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  regfile_mp #(.DATA_W(DW), .NUM_REG(NR), .NUM_RD(NRD), .BYPASS(1), .ZERO_REG(1)) dut0 (
    .i_clk(clock), .i_rst(reset), .i_ReadReg(readReg), .o_ReadData(readData0),
    .o_ReadBusy(readBusy0), .i_WrEn0(wrEn0), .i_WrReg0(wrReg0), .i_WrData0(wrData0),
    .i_WrEn1(wrEn1), .i_WrReg1(wrReg1), .i_WrData1(wrData1), .i_Alloc(alloc),
    .i_AllocReg(allocReg), .i_ProbeReg(probeReg), .o_ProbeData(probeData0)
  );

  regfile_mp #(.DATA_W(DW), .NUM_REG(NR), .NUM_RD(NRD), .BYPASS(0), .ZERO_REG(0)) dut1 (
    .i_clk(clock), .i_rst(reset), .i_ReadReg(readReg), .o_ReadData(readData1),
    .o_ReadBusy(readBusy1), .i_WrEn0(wrEn0), .i_WrReg0(wrReg0), .i_WrData0(wrData0),
    .i_WrEn1(wrEn1), .i_WrReg1(wrReg1), .i_WrData1(wrData1), .i_Alloc(alloc),
    .i_AllocReg(allocReg), .i_ProbeReg(probeReg), .o_ProbeData(probeData1)
  );

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [63:0] dutData(input int d, input int k);
    return (d == 0) ? readData0[k*DW +: DW] : readData1[k*DW +: DW];
  endfunction

  function automatic logic [63:0] dutBusy(input int d, input int k);
    return (d == 0) ? 64'(readBusy0[k]) : 64'(readBusy1[k]);
  endfunction

  function automatic logic [63:0] dutProbe(input int d);
    return (d == 0) ? probeData0 : probeData1;
  endfunction

  // Model of one read port for dut d (d==0: bypass + zero reg, d==1: neither).
  function automatic logic [63:0] modelRead(input int d, input int k, input bit wantBusy);
    logic [AW-1:0] a;
    bit byp, zr, hit0, hit1;
    a    = readReg[k*AW +: AW];
    byp  = (d == 0);
    zr   = (d == 0);
    hit0 = wrEn0 && (wrReg0 == a);
    hit1 = wrEn1 && (wrReg1 == a);
    if (reset) return 64'd0;
    if (zr && a == 0) return 64'd0;
    if (wantBusy) return byp ? 64'(modelBusy[d][a] && !(hit0 || hit1)) : 64'(modelBusy[d][a]);
    if (byp && hit1) return wrData1;
    if (byp && hit0) return wrData0;
    return modelRegs[d][a];
  endfunction

  // Queue the expectations for the inputs now applied, let them settle,
  // then pop and compare in the same order.
  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NRD; k++) begin
        expQ.push_back(modelRead(d, k, 1'b0));
        expQ.push_back(modelRead(d, k, 1'b1));
      end
      expQ.push_back(reset ? 64'd0 : modelRegs[d][probeReg]);
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NRD; k++) begin
        checkOutput($sformatf("d%0d_rd%0d_data", d, k), dutData(d, k), expQ.pop_front());
        checkOutput($sformatf("d%0d_rd%0d_busy", d, k), dutBusy(d, k), expQ.pop_front());
      end
      checkOutput($sformatf("d%0d_probe", d), dutProbe(d), expQ.pop_front());
    end
  endtask

  // Clock edge: update the model with the inputs held across the edge.
  task automatic advance();
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      bit zr;
      zr = (d == 0);
      if (reset) begin
        for (int r = 0; r < NR; r++) begin
          modelRegs[d][r] = '0;
          modelBusy[d][r] = 1'b0;
        end
      end else begin
        if (wrEn0 && !(zr && wrReg0 == 0)) begin
          modelRegs[d][wrReg0] = wrData0;
          modelBusy[d][wrReg0] = 1'b0;
        end
        if (wrEn1 && !(zr && wrReg1 == 0)) begin
          modelRegs[d][wrReg1] = wrData1;
          modelBusy[d][wrReg1] = 1'b0;
        end
        if (alloc && !(zr && allocReg == 0)) modelBusy[d][allocReg] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic setIdle();
    wrEn0 = 0; wrReg0 = '0; wrData0 = '0;
    wrEn1 = 0; wrReg1 = '0; wrData1 = '0;
    alloc = 0; allocReg = '0; probeReg = '0; readReg = '0;
  endtask

  task automatic setRead(input int a0, input int a1, input int a2, input int a3);
    readReg = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  function automatic logic [AW-1:0] rndAddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR-1));
  endfunction

  // Directed scenarios first, then a long random run against the model.
  initial begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NR; r++) begin
        modelRegs[d][r] = '0;
        modelBusy[d][r] = 1'b0;
      end
    setIdle();
    reset = 1;
    advance();
    advance();

    // Writes and alloc while reset is held must be discarded.
    wrEn0 = 1; wrReg0 = 3; wrData0 = 64'hDEAD;
    wrEn1 = 1; wrReg1 = 4; wrData1 = 64'hBEEF;
    alloc = 1; allocReg = 6;
    setRead(3, 4, 6, 1);
    applyStimulus();
    checkOutput("rst_rd_data", dutData(0, 0), 64'd0);
    advance();
    setIdle();
    reset = 0;
    for (int r = 0; r < NR; r++) begin
      setRead(r, (r+1)%NR, (r+2)%NR, (r+3)%NR);
      probeReg = AW'(r);
      applyStimulus();
      checkOutput("post_rst_data", dutData(0, 0), 64'd0);
      checkOutput("post_rst_busy", dutBusy(1, 0), 64'd0);
      advance();
    end

    // Same-cycle bypass of ALU write.
    wrEn0 = 1; wrReg0 = 5; wrData0 = 64'h1234; setRead(5, 5, 0, 1);
    applyStimulus();
    checkOutput("byp_r5", dutData(0, 0), 64'h1234);
    checkOutput("nobyp_r5", dutData(1, 0), 64'h0);
    advance();
    setIdle(); setRead(5, 2, 3, 4); probeReg = 5;
    applyStimulus();
    checkOutput("stored_r5_d0", dutData(0, 0), 64'h1234);
    checkOutput("stored_r5_d1", dutData(1, 0), 64'h1234);
    advance();

    // Both ports hit r7: load port wins.
    wrEn0 = 1; wrReg0 = 7; wrData0 = 64'hAA;
    wrEn1 = 1; wrReg1 = 7; wrData1 = 64'hBB; setRead(7, 7, 7, 7);
    applyStimulus();
    checkOutput("dual_wr_byp", dutData(0, 1), 64'hBB);
    advance();
    setIdle(); setRead(7, 7, 7, 7); probeReg = 7;
    applyStimulus();
    checkOutput("dual_wr_d0", dutData(0, 2), 64'hBB);
    checkOutput("dual_wr_d1", dutData(1, 2), 64'hBB);
    advance();

    // Register 0: hard-wired on dut0, ordinary on dut1.
    wrEn0 = 1; wrReg0 = 0; wrData0 = 64'hFFFF; alloc = 1; allocReg = 0; setRead(0, 0, 0, 0);
    applyStimulus();
    checkOutput("r0_byp_data", dutData(0, 0), 64'h0);
    checkOutput("r0_byp_busy", dutBusy(0, 0), 64'h0);
    advance();
    setIdle(); setRead(0, 0, 0, 0);
    applyStimulus();
    checkOutput("r0_zero_data", dutData(0, 3), 64'h0);
    checkOutput("r0_zero_busy", dutBusy(0, 3), 64'h0);
    checkOutput("r0_plain_data", dutData(1, 3), 64'hFFFF);
    checkOutput("r0_plain_busy", dutBusy(1, 3), 64'h1);
    checkOutput("r0_plain_probe", dutProbe(1), 64'hFFFF);
    advance();

    // Scoreboard on r9.
    alloc = 1; allocReg = 9; setRead(9, 9, 9, 9);
    applyStimulus();
    advance();
    setIdle(); setRead(9, 9, 9, 9);
    applyStimulus();
    checkOutput("r9_busy_d0", dutBusy(0, 0), 64'h1);
    checkOutput("r9_busy_d1", dutBusy(1, 0), 64'h1);
    advance();
    alloc = 1; allocReg = 9; wrEn1 = 1; wrReg1 = 9; wrData1 = 64'h42; setRead(9, 9, 9, 9);
    applyStimulus();
    checkOutput("r9_alloc_wr_byp", dutData(0, 0), 64'h42);
    advance();
    setIdle(); setRead(9, 9, 9, 9);
    applyStimulus();
    checkOutput("r9_realloc_busy", dutBusy(0, 1), 64'h1);
    checkOutput("r9_realloc_data", dutData(1, 1), 64'h42);
    advance();
    wrEn1 = 1; wrReg1 = 9; wrData1 = 64'h55; setRead(9, 9, 9, 9);
    applyStimulus();
    checkOutput("r9_wb_busy_byp", dutBusy(0, 2), 64'h0);
    checkOutput("r9_wb_busy_nobyp", dutBusy(1, 2), 64'h1);
    advance();
    setIdle(); setRead(9, 9, 9, 9);
    applyStimulus();
    checkOutput("r9_clear_d0", dutBusy(0, 3), 64'h0);
    checkOutput("r9_clear_d1", dutBusy(1, 3), 64'h0);
    advance();

    // Random traffic with occasional and one forced mid-run reset.
    for (int i = 0; i < 10000; i++) begin
      wrEn0 = $urandom_range(0, 1); wrReg0 = rndAddr(); wrData0 = {$urandom, $urandom};
      wrEn1 = $urandom_range(0, 1); wrReg1 = rndAddr(); wrData1 = {$urandom, $urandom};
      alloc = ($urandom_range(0, 2) == 0); allocReg = rndAddr();
      probeReg = rndAddr();
      readReg = {rndAddr(), rndAddr(), rndAddr(), rndAddr()};
      reset = (i == 5000) || ($urandom_range(0, 999) == 0);
      if (i == 5001) begin
        wrEn0 = 0; wrEn1 = 0;
      end
      applyStimulus();
      if (i == 5001) begin
        for (int k = 0; k < NRD; k++) begin
          checkOutput("midrun_rst_d0", dutData(0, k), 64'd0);
          checkOutput("midrun_rst_d1", dutData(1, k), 64'd0);
        end
      end
      advance();
      reset = 0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
